// File: rtl/sprite_blitter.sv
`timescale 1ns/1ps
// sprite_blitter: copies a SIZE_X x SIZE_Y sprite from ROM into the frame buffer, centred on (curX, curY).
// Latency: 2 cycles per skipped pixel, 3 per written pixel plus fb_ready stalls; done pulses 2 cycles after the last pixel.
// Backpressure: fb_we/fb_addr/fb_data held until fb_ready; start ignored while busy. SPRITE_BLITTER_FLIP_X_EN adds flip_x.
module sprite_blitter #(
  parameter int SIZE_X      = 70,
  parameter int SIZE_Y      = 70,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int DATA_W      = 4,
  parameter int TRANSPARENT = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        curX,
  input  logic [9:0]        curY,
`ifdef SPRITE_BLITTER_FLIP_X_EN
  input  logic              flip_x,
`endif
  output logic [18:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [18:0]       fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done
);

  localparam int TXW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int TYW = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, EVAL, WRITE, DONE} state_t;

  state_t             state;
  logic [TXW-1:0]     tx, nxt_tx;
  logic [TYW-1:0]     ty, nxt_ty;
  logic signed [10:0] left, up;
  logic               armed;
  logic               flip_in, flip_q;
  logic               last_px, pix_ok;
  int                 sx, sy;
  int                 start_rom, nxt_rom, fb_idx;

  // ROM index of sprite pixel (col,row), optionally mirrored horizontally
  function automatic int rom_index(input int col, input int row, input logic flip);
    int c;
    c = flip ? (SIZE_X - 1 - col) : col;
    return row * SIZE_X + c;
  endfunction

`ifdef SPRITE_BLITTER_FLIP_X_EN
  assign flip_in = flip_x;
`else
  assign flip_in = 1'b0;
`endif

  // Counter advance, screen coordinates and pixel-write decision
  always_comb begin
    nxt_tx    = tx;
    nxt_ty    = ty;
    last_px   = (tx == TXW'(SIZE_X - 1)) && (ty == TYW'(SIZE_Y - 1));
    if (tx == TXW'(SIZE_X - 1)) begin
      nxt_tx = '0;
      nxt_ty = ty + 1'b1;
    end else begin
      nxt_tx = tx + 1'b1;
    end
    nxt_rom   = rom_index(int'(nxt_tx), int'(nxt_ty), flip_q);
    start_rom = rom_index(0, 0, flip_in);
    // origin may be negative and sx may exceed the 11-bit range, so work in int
    sx        = int'(left) + int'(tx);
    sy        = int'(up) + int'(ty);
    pix_ok    = (sx >= 0) && (sx < SCREEN_W) && (sy >= 0) && (sy < SCREEN_H) &&
                (rom_data != DATA_W'(TRANSPARENT));
    fb_idx    = sy * SCREEN_W + sx;
  end

  // Blit state machine with registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      tx       <= '0;
      ty       <= '0;
      left     <= '0;
      up       <= '0;
      flip_q   <= 1'b0;
      armed    <= 1'b0;
      rom_addr <= '0;
      fb_addr  <= '0;
      fb_data  <= '0;
      fb_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // first edge after reset release never accepts start
      armed <= 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          // busy still high here means this is the done cycle; start is dropped
          if (start && armed && !busy) begin
            left     <= 11'(int'(curX) - SIZE_X / 2);
            up       <= 11'(int'(curY) - SIZE_Y / 2);
            tx       <= '0;
            ty       <= '0;
            flip_q   <= flip_in;
            rom_addr <= 19'(start_rom);
            busy     <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: state <= EVAL;
        EVAL: begin
          if (pix_ok) begin
            fb_addr <= 19'(fb_idx);
            fb_data <= rom_data;
            fb_we   <= 1'b1;
            state   <= WRITE;
          end else if (last_px) begin
            state <= DONE;
          end else begin
            tx       <= nxt_tx;
            ty       <= nxt_ty;
            rom_addr <= 19'(nxt_rom);
            state    <= ADDR;
          end
        end
        WRITE: begin
          if (fb_ready) begin
            fb_we <= 1'b0;
            if (last_px) begin
              state <= DONE;
            end else begin
              tx       <= nxt_tx;
              ty       <= nxt_ty;
              rom_addr <= 19'(nxt_rom);
              state    <= ADDR;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
`timescale 1ns/1ps
// tb_sprite_blitter: directed and randomized blits checked against a pixel-list reference model.
// Latency: done cycle and per-write order compared against the model.
// Backpressure: fb_ready driven per cycle (always, stalled first write, random).
module tb_sprite_blitter;

  localparam int SX = 70;
  localparam int SY = 70;
  localparam int N  = SX * SY;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [9:0]  curX, curY;
  logic        flip_x;
  logic [18:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        busy;
  logic        done;

  logic [3:0]  rom [0:N-1];

  int n_checks = 0;
  int n_fail   = 0;

  int exp_a[$], exp_d[$], got_a[$], got_d[$];
  int done_cyc, done_cnt, busy_after, stab_bad, stab_cyc, we_cnt, rom0, rom1;

  always #5 Clk = ~Clk;

  // synchronous ROM: data one cycle after address
  always @(posedge Clk) rom_data <= (rom_addr < 19'(N)) ? rom[rom_addr] : 4'd0;

  sprite_blitter dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .curX     (curX),
    .curY     (curY),
`ifdef SPRITE_BLITTER_FLIP_X_EN
    .flip_x   (flip_x),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of (address, data) writes in raster order of the sprite
  task automatic build_model(input int cx, input int cy, input bit flp);
    exp_a.delete();
    exp_d.delete();
    for (int row = 0; row < SY; row++) begin
      for (int col = 0; col < SX; col++) begin
        int px, py, idx;
        px  = cx - SX / 2 + col;
        py  = cy - SY / 2 + row;
        idx = row * SX + (flp ? (SX - 1 - col) : col);
        if (px >= 0 && px < 640 && py >= 0 && py < 480 && rom[idx] != 4'd0) begin
          exp_a.push_back(py * 640 + px);
          exp_d.push_back(int'(rom[idx]));
        end
      end
    end
  endtask

  task automatic check_writes(input string t);
    int mism, n;
    mism = 0;
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++)
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) mism++;
    check($sformatf("%s_write_count", t), got_a.size(), exp_a.size());
    check($sformatf("%s_write_seq_mismatches", t), mism, 0);
  endtask

  // mode 0: fb_ready always 1; mode 1: first write stalled 3 cycles; mode 2: random fb_ready
  task automatic run_blit(input string t, input int cx, input int cy, input int mode, input bit mid_start);
    int cyc, phase, ref_a, ref_d;
    got_a.delete(); got_d.delete();
    done_cyc = 0; done_cnt = 0; busy_after = -1; stab_bad = 0; stab_cyc = 0;
    we_cnt = 0; rom0 = -1; rom1 = -1; phase = -1; ref_a = 0; ref_d = 0;
    @(negedge Clk);
    curX = 10'(cx); curY = 10'(cy); start = 1'b1; fb_ready = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check($sformatf("%s_busy_rise", t), busy, 1);
    cyc = 1;
    while (cyc < 40000) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = busy;
      if (cyc == 1) rom0 = int'(rom_addr);
      else if (rom1 < 0 && int'(rom_addr) != rom0) rom1 = int'(rom_addr);
      start = mid_start && (cyc == 100 || done);
      if (fb_we) we_cnt++;
      case (mode)
        0: fb_ready = 1'b1;
        1: begin
          if (fb_we && phase < 0) begin
            phase = 0; ref_a = int'(fb_addr); ref_d = int'(fb_data);
          end
          if (phase >= 0 && phase < 4) begin
            if (!fb_we || int'(fb_addr) != ref_a || int'(fb_data) != ref_d) stab_bad++;
            stab_cyc++;
            fb_ready = (phase == 3);
            phase++;
          end else begin
            fb_ready = 1'b1;
          end
        end
        default: fb_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (fb_we && fb_ready) begin
        got_a.push_back(int'(fb_addr));
        got_d.push_back(int'(fb_data));
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      @(negedge Clk);
      cyc++;
    end
    start = 1'b0;
    fb_ready = 1'b1;
    check($sformatf("%s_done_seen_in_budget", t), done_cyc != 0, 1);
    check($sformatf("%s_done_pulses", t), done_cnt, 1);
    check($sformatf("%s_busy_after_done", t), busy_after, 0);
  endtask

  task automatic pulse_reset();
    #1 Reset_n = 1'b0;
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    int k, r0, cx, cy, maxa;
    Reset_n = 1'b0; start = 1'b0; curX = '0; curY = '0; flip_x = 1'b0; fb_ready = 1'b1;
    for (int i = 0; i < N; i++) rom[i] = 4'd5;
    repeat (3) @(negedge Clk);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_fb_addr", fb_addr, 0);
    check("reset_fb_data", fb_data, 0);
    check("reset_fb_we", fb_we, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // start coinciding with reset release is dropped
    Reset_n = 1'b1; start = 1'b1; curX = 10'd320; curY = 10'd240;
    @(negedge Clk);
    start = 1'b0;
    check("start_at_release_ignored", busy, 0);
    repeat (2) @(negedge Clk);

    // centred opaque sprite, with extra starts mid-blit and in the done cycle
    run_blit("centre", 320, 240, 0, 1'b1);
    build_model(320, 240, flip_x);
    check_writes("centre");
    check("centre_writes_4900", got_a.size(), 4900);
    check("centre_first_addr", (got_a.size() > 0) ? got_a[0] : -1, 131485);
    check("centre_last_addr", (got_a.size() > 0) ? got_a[got_a.size()-1] : -1, 175714);
    check("centre_done_cycle", done_cyc, 3 * 4900 + 2);
    check("centre_rom_first", rom0, 0);
    check("centre_rom_second", rom1, 1);

    // first write stalled three cycles
    run_blit("bp", 320, 240, 1, 1'b0);
    build_model(320, 240, flip_x);
    check_writes("bp");
    check("bp_stable_cycles", stab_cyc, 4);
    check("bp_unstable", stab_bad, 0);
    check("bp_done_cycle", done_cyc, 3 * 4900 + 2 + 3);

    // top-left clip
    run_blit("clip", 10, 10, 0, 1'b0);
    build_model(10, 10, flip_x);
    check_writes("clip");
    check("clip_writes_2025", got_a.size(), 2025);
    check("clip_first_addr", (got_a.size() > 0) ? got_a[0] : -1, 0);
    maxa = 0;
    foreach (got_a[i]) if (got_a[i] > maxa) maxa = got_a[i];
    check("clip_max_addr_below_28800", maxa < 45 * 640, 1);
    check("clip_done_cycle", done_cyc, 3 * 2025 + 2 * (4900 - 2025) + 2);

    // fully transparent sprite
    for (int i = 0; i < N; i++) rom[i] = 4'd0;
    run_blit("transp", 320, 240, 0, 1'b0);
    check("transp_we_cycles", we_cnt, 0);
    check("transp_done_cycle", done_cyc, 2 * 4900 + 2);
    for (int i = 0; i < N; i++) rom[i] = 4'd5;

`ifdef SPRITE_BLITTER_FLIP_X_EN
    // mirrored addressing: first ROM accesses walk down from the right edge
    @(negedge Clk);
    flip_x = 1'b1; curX = 10'd320; curY = 10'd240; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    r0 = int'(rom_addr);
    k = 0;
    while (int'(rom_addr) == r0 && k < 10) begin
      @(negedge Clk);
      k++;
    end
    check("flip_rom_first", r0, 69);
    check("flip_rom_second", rom_addr, 68);
    pulse_reset();
    flip_x = 1'b0;
`endif

    // reset while a write is stalled
    @(negedge Clk);
    curX = 10'd320; curY = 10'd240; start = 1'b1; fb_ready = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    k = 0;
    while (!fb_we && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("abort_reached_write", fb_we, 1);
    pulse_reset();
    fb_ready = 1'b1;

    // random sprite near the bottom-right corner, random backpressure
    for (int i = 0; i < N; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    cx = $urandom_range(600, 660);
    cy = $urandom_range(440, 500);
`ifdef SPRITE_BLITTER_FLIP_X_EN
    flip_x = 1'($urandom_range(0, 1));
`endif
    run_blit("rand", cx, cy, 2, 1'b0);
    build_model(cx, cy, flip_x);
    check_writes("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Copies one SIZE_X x SIZE_Y sprite from sprite ROM into the 640x480 frame buffer, centred on (curX, curY).
- Write-side counterpart of the per-pixel sprite address path: it produces ROM read addresses and frame-buffer write addresses/data.
- Handles screen-edge clipping and transparent pixels.
- Sits between game logic (issues start) and the frame-buffer write port.

Parameters:
- SIZE_X, 70, sprite width in pixels
- SIZE_Y, 70, sprite height in pixels
- SCREEN_W, 640, frame-buffer width
- SCREEN_H, 480, frame-buffer height
- DATA_W, 4, palette-index width
- TRANSPARENT, 0, palette index that is never written

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to blit; sampled only in IDLE
- curX  in  10  sprite centre X, latched on start
- curY  in  10  sprite centre Y, latched on start
- rom_addr  out  19  sprite ROM read address
- rom_data  in  DATA_W  ROM output; valid exactly 1 cycle after rom_addr
- fb_addr  out  19  frame-buffer write address
- fb_data  out  DATA_W  frame-buffer write data
- fb_we  out  1  write request; held until fb_ready
- fb_ready  in  1  frame buffer accepts write this cycle when fb_we=1
- busy  out  1  blit in progress
- done  out  1  one-cycle pulse at blit completion

Behaviour:
- Reset values: rom_addr=0, fb_addr=0, fb_data=0, fb_we=0, busy=0, done=0, state=IDLE, tx=ty=0.
- Reset is asynchronous. Asserting it mid-blit aborts immediately; fb_we drops without waiting for fb_ready.
- States and transitions:
  - IDLE -> ADDR on start. Latch left = curX - SIZE_X/2 and up = curY - SIZE_Y/2 as 11-bit signed values; negative results are legal. Clear tx, ty. busy goes 1 the next cycle.
  - ADDR: rom_addr = ty*SIZE_X + tx. Next state is EVAL.
  - EVAL: rom_data is valid. sx = left+tx, sy = up+ty (signed).
    - Write the pixel iff 0<=sx<SCREEN_W, 0<=sy<SCREEN_H and rom_data != TRANSPARENT.
    - If writing: register fb_addr = sy*SCREEN_W + sx and fb_data = rom_data, set fb_we=1, go to WRITE.
    - Otherwise advance the counters and go to ADDR, or to DONE if this was the last pixel.
  - WRITE: hold fb_we, fb_addr and fb_data stable until a cycle with fb_ready=1. In that cycle the write completes; fb_we=0 next cycle. Advance the counters, then go to ADDR or DONE.
  - DONE: done=1 for exactly one cycle. busy=0 from the following cycle. Return to IDLE.
- Counter advance:
  - tx increments.
  - At tx=SIZE_X-1: tx wraps to 0 and ty increments.
  - The last pixel is tx=SIZE_X-1, ty=SIZE_Y-1.
- Cost per pixel: skipped pixel = 2 cycles; written pixel = 3 cycles plus fb_ready stall cycles.
- Arithmetic:
  - Address products are computed at full width, then truncated to 19 bits. The maximum 479*640+639 = 307199 fits.
  - No wrap-around is allowed: any off-screen pixel is skipped, not wrapped.
- Simultaneous events:
  - start while busy or in DONE is ignored; it is not queued.
  - start in the same cycle as reset release is ignored.
- curX/curY may change during a blit with no effect until the next start.

Optional Feature:
- Macro: SPRITE_BLITTER_FLIP_X_EN
- When defined:
  - Adds input port flip_x (1 bit), latched on start.
  - If the latched value is 1, rom_addr = ty*SIZE_X + (SIZE_X-1-tx). Destination sx is unchanged, so the sprite is mirrored horizontally.
- When undefined:
  - No flip_x port.
  - Addressing is always ty*SIZE_X + tx.

Test Plan:
- Centred, all-opaque ROM (value 5), curX=320, curY=240, fb_ready=1:
  - exactly 4900 writes.
  - First write fb_addr = 205*640+285 = 131485.
  - Last write fb_addr = 274*640+354 = 175714.
  - done pulses once at cycle 3*4900 + 2 after start (±1 is not allowed).
- Top-left clip, curX=10, curY=10:
  - left=up=-25, so only tx,ty >= 25 are written: 45*45 = 2025 writes.
  - First write fb_addr = 0.
  - No fb_addr >= 45*640.
- All-TRANSPARENT ROM: zero fb_we assertions; done at cycle 2*4900 + 2.
- Backpressure: fb_ready low for 3 cycles on the first write → fb_we, fb_addr and fb_data are stable for all 4 cycles; 4900 writes still complete.
- start pulsed mid-blit, then Reset_n low for 1 cycle mid-WRITE:
  - the second start is ignored.
  - After reset, all outputs are 0 and the state is IDLE.
  - A new start performs a full, correct blit.
- With SPRITE_BLITTER_FLIP_X_EN defined and flip_x=1 → the first ROM access in the blit is rom_addr=69 and the second is 68.
